// File: rtl/uart_pkg.sv
// Shared UART types and constants: autobaud state encoding and measurement geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        MEASURE,
        LOCKED
    } autobaud_state_t;

    localparam int unsigned AB_SEGMENTS         = 8;
    localparam int unsigned AB_OVERSAMPLE_SHIFT = 4;
    localparam int unsigned AB_SEG_SHIFT        = $clog2(AB_SEGMENTS);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw RX line with registered fall/rise flags.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic fall,
    output logic rise
);

    logic meta;
    logic syncQ;
    logic prevQ;

    // Idle-high line, so every stage resets to 1 to avoid a false edge out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b1;
            syncQ <= 1'b1;
            prevQ <= 1'b1;
            fall  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta  <= rx;
            syncQ <= meta;
            prevQ <= syncQ;
            fall  <= prevQ & ~syncQ;
            rise  <= ~prevQ & syncQ;
        end
    end

endmodule

// File: rtl/uart_autobaud.sv
// Autobaud controller: measures a 0x55 sync character and emits bit / 1/16-bit divisors.
// Optional per-segment tolerance check is enabled by defining AUTOBAUD_VERIFY_EN.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W   = 17,
    parameter int unsigned MIN_BIT = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 rx,
    input  logic                                 start,
    output logic [CNT_W-1:0]                     baud_div,
    output logic [CNT_W-AB_OVERSAMPLE_SHIFT-1:0] rx_div,
    output logic                                 locked,
    output logic                                 err
);

    localparam int unsigned TOT_W = CNT_W + AB_SEG_SHIFT;
    localparam int unsigned SEG_W = AB_SEG_SHIFT;
    localparam int unsigned RX_W  = CNT_W - AB_OVERSAMPLE_SHIFT;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 fall;
    logic                 rise;
    autobaud_state_t      state;
    logic [CNT_W-1:0]     segCnt;
    logic [TOT_W-1:0]     total;
    logic [SEG_W-1:0]     segIdx;
    logic [CNT_W-1:0]     segWidth;
    logic [TOT_W-1:0]     totalNext;
    logic                 segEdge;
    logic                 lastSeg;
    logic                 minFail;
    logic                 tolFail;

    uart_rx_sync uRxSync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .fall  (fall),
        .rise  (rise)
    );

    // Counter restarts at 0 on each close, so the closing segment spans segCnt+1 cycles.
    assign segEdge   = fall | rise;
    assign segWidth  = segCnt + CNT_W'(1);
    assign totalNext = total + TOT_W'(segWidth);
    assign lastSeg   = (segIdx == SEG_W'(AB_SEGMENTS - 1));
    assign minFail   = (segIdx == '0) && (segWidth < CNT_W'(MIN_BIT));

`ifdef AUTOBAUD_VERIFY_EN
    logic [CNT_W-1:0] w0;
    logic [CNT_W-1:0] segDiff;

    assign segDiff = (segWidth >= w0) ? (segWidth - w0) : (w0 - segWidth);
    assign tolFail = (segIdx != '0) && (segDiff > (w0 >> 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w0 <= '0;
        end else if (state == MEASURE && segEdge && segIdx == '0) begin
            w0 <= segWidth;
        end
    end
`else
    assign tolFail = 1'b0;
`endif

    // Controller; start overrides any close or reject in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            segCnt   <= '0;
            total    <= '0;
            segIdx   <= '0;
            baud_div <= '0;
            rx_div   <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (start) begin
                state  <= HUNT;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    HUNT: begin
                        if (fall) begin
                            segCnt <= '0;
                            total  <= '0;
                            segIdx <= '0;
                            state  <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (segCnt == CNT_MAX) begin
                            err   <= 1'b1;
                            state <= HUNT;
                        end else if (segEdge) begin
                            if (minFail || tolFail) begin
                                err   <= 1'b1;
                                state <= HUNT;
                            end else begin
                                total  <= totalNext;
                                segCnt <= '0;
                                segIdx <= segIdx + SEG_W'(1);
                                if (lastSeg) begin
                                    baud_div <= CNT_W'(totalNext >> AB_SEG_SHIFT);
                                    rx_div   <= RX_W'(totalNext >> (AB_SEG_SHIFT + AB_OVERSAMPLE_SHIFT));
                                    locked   <= 1'b1;
                                    state    <= LOCKED;
                                end
                            end
                        end else begin
                            segCnt <= segCnt + CNT_W'(1);
                        end
                    end
                    LOCKED: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: table-driven sync frames plus corner-case sequences.
module tb_uart_autobaud;

    localparam int unsigned CNT_W   = 14;
    localparam int unsigned MIN_BIT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             rx;
    logic             start;
    logic [CNT_W-1:0] baudDiv;
    logic [CNT_W-5:0] rxDiv;
    logic             locked;
    logic             err;

    uart_autobaud #(.CNT_W(CNT_W), .MIN_BIT(MIN_BIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .start    (start),
        .baud_div (baudDiv),
        .rx_div   (rxDiv),
        .locked   (locked),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit isErr;
        int div;
        int rxd;
    } exp_t;

    typedef struct {
        int w[8];
        int stopSeg;
        bit expErr;
        int expDiv;
        int expRx;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   checks  = 0;
    int   errors  = 0;
    int   errSeen = 0;
    logic errQ    = 1'b0;
    logic lockedQ = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic popCheck(input bit isErr);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s expected none", isErr ? "err" : "lock");
        end else begin
            e = sb.pop_front();
            check("event_kind", int'(isErr), int'(e.isErr));
            if (!isErr && !e.isErr) begin
                check("baud_div", int'(baudDiv), e.div);
                check("rx_div", int'(rxDiv), e.rxd);
            end
        end
    endtask

    // Scoreboard consumer: every err pulse and every lock rise pops one expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (err) begin
                errSeen++;
                check("err_width", int'(errQ), 0);
                popCheck(1'b1);
            end
            if (locked && !lockedQ) popCheck(1'b0);
        end
        errQ    = err;
        lockedQ = locked;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic expectLock(input int d, input int r);
        exp_t e;
        e.isErr = 1'b0;
        e.div   = d;
        e.rxd   = r;
        sb.push_back(e);
    endtask

    task automatic expectErr();
        exp_t e;
        e.isErr = 1'b1;
        e.div   = 0;
        e.rxd   = 0;
        sb.push_back(e);
    endtask

    // Drives start bit and data bits of 0x55 as segments; stops early after stopSeg.
    task automatic sendFrame(input int w[8], input int stopSeg, input bit doStart, input bit expLock);
        if (doStart) pulseStart();
        step(4);
        rx = 1'b0;
        for (int i = 0; i <= stopSeg; i++) begin
            step(w[i]);
            rx = ~rx;
        end
        if (expLock) begin
            step(3);
            check("lock_early", int'(locked), 0);
            step(1);
            check("lock_latency", int'(locked), 1);
            step(12);
            rx = 1'b1;
            step(16);
        end else begin
            step(8);
            pulseStart();
            rx = 1'b1;
            step(8);
        end
        check("pending", sb.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w200[8];
        int w868[8];
        int n;
        int e0;

        for (int i = 0; i < 8; i++) begin
            w200[i] = 200;
            w868[i] = 868;
            tbl[0].w[i] = 868;
            tbl[2].w[i] = 16;
            tbl[3].w[i] = 16;
            tbl[4].w[i] = 200;
            tbl[5].w[i] = 1500;
            tbl[6].w[i] = 868;
        end
        tbl[0].stopSeg = 7; tbl[0].expErr = 0; tbl[0].expDiv = 868;  tbl[0].expRx = 54;
        tbl[1].w = '{870, 866, 869, 867, 868, 868, 871, 865};
        tbl[1].stopSeg = 7; tbl[1].expErr = 0; tbl[1].expDiv = 868;  tbl[1].expRx = 54;
        tbl[2].w[7] = 20;
        tbl[2].stopSeg = 7; tbl[2].expErr = 0; tbl[2].expDiv = 16;   tbl[2].expRx = 1;
        tbl[3].w[7] = 21;
`ifdef AUTOBAUD_VERIFY_EN
        tbl[3].stopSeg = 7; tbl[3].expErr = 1; tbl[3].expDiv = 0;    tbl[3].expRx = 0;
`else
        tbl[3].stopSeg = 7; tbl[3].expErr = 0; tbl[3].expDiv = 16;   tbl[3].expRx = 1;
`endif
        tbl[4].w[0] = 15;
        tbl[4].stopSeg = 0; tbl[4].expErr = 1; tbl[4].expDiv = 0;    tbl[4].expRx = 0;
        tbl[5].stopSeg = 7; tbl[5].expErr = 0; tbl[5].expDiv = 1500; tbl[5].expRx = 93;
        tbl[6].w[4] = 1200;
`ifdef AUTOBAUD_VERIFY_EN
        tbl[6].stopSeg = 4; tbl[6].expErr = 1; tbl[6].expDiv = 0;    tbl[6].expRx = 0;
`else
        tbl[6].stopSeg = 7; tbl[6].expErr = 0; tbl[6].expDiv = 909;  tbl[6].expRx = 56;
`endif

        reset = 1'b1;
        rx    = 1'b1;
        start = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        check("reset_baud_div", int'(baudDiv), 0);
        check("reset_rx_div", int'(rxDiv), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_err", int'(err), 0);

        // Edges while IDLE must not start a measurement.
        rx = 1'b0;
        step(40);
        rx = 1'b1;
        step(10);
        check("idle_no_lock", int'(locked), 0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].expErr) expectErr();
            else expectLock(tbl[i].expDiv, tbl[i].expRx);
            sendFrame(tbl[i].w, tbl[i].stopSeg, 1'b1, !tbl[i].expErr);
        end

        // Short low glitch is rejected by the minimum start-bit width.
        pulseStart();
        expectErr();
        rx = 1'b0;
        step(8);
        rx = 1'b1;
        step(12);
        check("glitch_locked", int'(locked), 0);
        check("glitch_pending", sb.size(), 0);

        // Line stuck low: counter saturates and the attempt is rejected.
        pulseStart();
        expectErr();
        e0 = errSeen;
        n  = 0;
        rx = 1'b0;
        while (errSeen == e0 && n < 17000) begin
            step(1);
            n++;
        end
        check("timeout_err", errSeen - e0, 1);
        check("timeout_not_early", int'(n >= 16000), 1);
        rx = 1'b1;
        step(8);

        // Block is back in HUNT, so a frame without start still locks.
        expectLock(200, 12);
        sendFrame(w200, 7, 1'b0, 1'b1);

        // Re-arm: lock drops but divisors hold; abandon mid-measurement silently.
        pulseStart();
        step(2);
        check("rehunt_locked", int'(locked), 0);
        check("rehunt_hold_div", int'(baudDiv), 200);
        rx = 1'b0;
        step(200);
        rx = 1'b1;
        step(200);
        rx = 1'b0;
        step(100);
        pulseStart();
        rx = 1'b1;
        step(20);
        check("abandon_pending", sb.size(), 0);
        expectLock(868, 54);
        sendFrame(w868, 7, 1'b0, 1'b1);

        // Asynchronous reset in the middle of d2.
        pulseStart();
        rx = 1'b0;
        step(200);
        rx = 1'b1;
        step(200);
        rx = 1'b0;
        step(200);
        rx = 1'b1;
        step(100);
        reset = 1'b1;
        #1;
        check("midreset_baud_div", int'(baudDiv), 0);
        check("midreset_rx_div", int'(rxDiv), 0);
        check("midreset_locked", int'(locked), 0);
        check("midreset_err", int'(err), 0);
        step(2);
        reset = 1'b0;
        step(5);
        expectLock(868, 54);
        sendFrame(w868, 7, 1'b1, 1'b1);

        check("final_pending", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Autobaud controller for the UART baud generator. It watches the serial receive line for the sync character 0x55, measures bit timing in `clk` cycles and produces the clocks-per-bit and clocks-per-1/16-bit divisors that configure the transmit and receive baud ticks at runtime. It sits between the RX pad and the baud generator's divisor inputs and replaces the compile-time `BAUD_RATE` choice when autobaud is in use.

## Interface
- `CNT_W`, default 17: segment counter width. At 100 MHz this supports bit times down to about 763 baud.
- `MIN_BIT`, default 16: minimum accepted start-bit width, in `clk` cycles.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `start`  in  1  one-cycle pulse that arms detection and discards any current lock.
- `baud_div`  out  CNT_W  clocks per bit; valid while `locked`.
- `rx_div`  out  CNT_W-4  clocks per 1/16 bit; valid while `locked`.
- `locked`  out  1  divisors valid; held until the next `start` or `reset`.
- `err`  out  1  one-cycle pulse when a measurement attempt is rejected.

## Operation
- **Input conditioning:** `rx` passes through a 2-FF synchronizer, then a registered edge detector (fall/rise). All timing uses the synchronized line.
- **States:** IDLE, HUNT, MEASURE, LOCKED.
- **IDLE** (reset state). `start` -> HUNT.
- **HUNT.** A falling edge clears the segment counter, clears `total`, sets segment index 0 -> MEASURE.
- **MEASURE.** The segment counter increments every cycle. Each edge of either polarity closes a segment:
  - Segment 0 is the start bit and its width is stored as W0.
  - `total` accumulates every segment width; `total` is CNT_W+3 bits wide.
  - After segment 7 closes (the 5th falling edge, start of d7), `baud_div = total>>3`, `rx_div = total>>7` (truncating) -> LOCKED.
- **Rejections** (each pulses `err` and returns to HUNT):
  - W0 < MIN_BIT.
  - The segment counter reaches all-ones (timeout; it saturates, no wrap).
  - A tolerance failure, when enabled (see Configuration).
- **LOCKED.** Edges on `rx` are ignored. `start` -> HUNT with `locked` cleared.
- **`start` in any state** -> HUNT. In MEASURE this abandons the measurement without pulsing `err`.
- **Simultaneous events:** `start` takes priority over a segment close or a rejection in the same cycle.

## Timing
- **Reset values:** `baud_div`=0, `rx_div`=0, `locked`=0, `err`=0, state IDLE, synchronizer flops = 1.
- **Edge latency:** a change on `rx` reaches the edge detector 3 cycles later.
- **Lock latency:** `locked` rises and the divisors update together, on the clock edge after the cycle in which the edge detector flags the final falling edge. That is 4 cycles after the raw edge.
- **Divisor stability:** the divisor outputs change only on entry to LOCKED. They keep their old values while re-hunting, but are qualified by `locked`.
- **`err`:** registered, exactly one cycle wide.
- **Reset mid-measurement:** reset returns the block immediately to IDLE with all outputs at reset values.

## Configuration
- **`AUTOBAUD_VERIFY_EN` defined:** each of segments 1..7 must satisfy |Wi − W0| ≤ W0>>2. On the first violating segment close, pulse `err` and return to HUNT.
- **`AUTOBAUD_VERIFY_EN` undefined:** no per-segment comparison and no W0 storage beyond the minimum-width check. Only the MIN_BIT check and the timeout reject.

## Structure
- **Package `uart_pkg`:**
  - state enum `autobaud_state_t` (IDLE, HUNT, MEASURE, LOCKED);
  - constant `AB_SEGMENTS = 8`;
  - constant `AB_OVERSAMPLE_SHIFT = 4`.
- **Sub-module `uart_rx_sync`:** 2-FF synchronizer plus registered rise/fall detect. It is reused by the UART receiver.

## Test plan
- 100 MHz clk, 0x55 sent at 115200 baud (868 cycles/bit) after `start` -> `locked`=1, `baud_div`=868, `rx_div`=54, no `err`.
- 0x55 sent at 9600 baud (10417 cycles/bit) -> `baud_div`=10417, `rx_div`=651.
- With `AUTOBAUD_VERIFY_EN`, 0x55 at 868 cycles/bit with the d3 bit stretched to 1200 cycles -> one `err` pulse, then a clean 0x55 locks at 868.
- 8-cycle low glitch on `rx` in HUNT -> `err` pulse (W0 < MIN_BIT), `locked` stays 0.
- `rx` held low after a falling edge for 2^17 cycles -> `err` pulse at saturation, state HUNT.
- Assert `reset` midway through the d2 bit -> all outputs 0 within the same cycle. Then `start` plus a clean 0x55 at 115200 -> `baud_div`=868.
